fractcam_rule_writer: RTL and testbench
=======================================

Name: fractcam_rule_writer

Overview:
- Upstream update stage of the FRACTCAM W40 datapath. Accepts one ternary rule (key, mask, slot select) per request and programs it into the LUTRAM-based match array.
- It sweeps all 2^SUB_W LUTRAM addresses and writes one match bit per key sub-field at each address.
- It feeds the same key/sel-driven array that the search-side stimulus drives. It also drives the array's write port while search traffic is held off through busy.

Parameters:
key_size, 40, rule/key width in bits
SN, 4, width of slot (rule) select sent to the array
SUB_W, 6, LUTRAM address width = key bits per sub-field
NSUB, 7, number of sub-fields = ceil(key_size/SUB_W)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  rule update request
req_ready  output  1  block can accept a request
rule_key  input  key_size  rule value bits
rule_mask  input  key_size  1 = don't-care bit
rule_en  input  1  1 = program rule, 0 = invalidate slot (write all zeros)
sel  input  SN  target slot
lut_we  output  1  write strobe to LUTRAM array
lut_addr  output  SUB_W  LUTRAM address being written
lut_sel  output  SN  slot being written
lut_wdata  output  NSUB  one match bit per sub-field
busy  output  1  update in progress; search must be stalled
done  output  1  one-cycle pulse when update completes

Behaviour:
- Reset (reset=0, async): state IDLE; req_ready=1; lut_we=0, lut_addr=0, lut_sel=0, lut_wdata=0, busy=0, done=0; captured registers cleared.
- Reset asserted mid-sweep aborts immediately. Partially written slot content is undefined; no done pulse is issued.
- Handshake: a transfer occurs on a rising edge with req_valid&req_ready. Inputs are sampled only on that edge. req_ready=1 only in IDLE. Requests presented while busy are not accepted and must be held by the source.
- FSM: IDLE -> WRITE on accept. WRITE -> DONE after address 2^SUB_W-1 is written. DONE -> IDLE after one cycle.
- WRITE, cycle k (k=0..2^SUB_W-1, first WRITE cycle is the edge after accept):
  - lut_we=1, lut_addr=k, lut_sel=captured sel.
  - lut_wdata[i] = rule_en & (((k ^ key_i) & ~mask_i) == 0), where key_i/mask_i are bits [i*SUB_W +: SUB_W] of the captured key/mask.
- Last sub-field padding: bits beyond key_size are treated as key=0, mask=0. The search side drives zeros there, so a padded address bit set to 1 gives a mismatch.
- busy=1 in WRITE and DONE. done=1 only in DONE. lut_we=0 outside WRITE. lut_addr returns to 0 in IDLE.
- Latency: accept at edge T. Writes occupy cycles T+1..T+64 (SUB_W=6). done high in cycle T+65. req_ready high again from T+66, so a back-to-back accept is possible at edge T+66. Throughput is one rule per 66 cycles.
- Counter: SUB_W-bit address counter with terminal detect at all-ones. No wrap occurs inside a sweep.
- Same sel written twice: the second sweep fully overwrites the first.
- All outputs registered; no combinational path from inputs to outputs except none (req_ready is state-decoded).

Test Plan:
1. Reset held low 3 cycles, then released -> req_ready=1, busy=0, lut_we=0, done=0, all outputs 0.
2. Exact rule: key=40'h00_0000_0003, mask=0, sel=4'h5, rule_en=1 -> 64 writes with lut_sel=5. At addr 3, lut_wdata[0]=1. At addr 0, lut_wdata[6:1]=6'h3F and bit0=0. At every other address, all bits are 0 except bits[6:1] at addr 0. done pulses exactly at cycle T+65.
3. Full wildcard: mask=40'hFF_FFFF_FFFF, key arbitrary. lut_wdata[5:0]=6'h3F at every address. lut_wdata[6]=1 only at addresses with bits[5:4]=00 (16 addresses).
4. Invalidate: rule_en=0, sel=4'hA -> 64 writes, lut_wdata=0 every cycle, lut_sel=A.
5. req_valid held high with two requests (sel=1, then sel=2) -> second accepted at T+66. req_ready=0 from T+1 to T+65. No write cycles overlap.
6. reset driven low during cycle T+30 of a sweep -> outputs go to reset values asynchronously, no done pulse. A new request after release is accepted and completes normally.

Source files
------------

// File: rtl/fractcam_rule_writer.sv
// ---------------------------------------------------------------------------
// fractcam_rule_writer
//
// Programs one ternary rule into the FRACTCAM LUTRAM match array. For each
// accepted request it sweeps every LUTRAM address (0 .. 2^SUB_W-1). At each
// address it writes one match bit per key sub-field into the selected slot.
// While the sweep runs, busy stays high so that search traffic is held off
// the shared array.
//
// Ports:
//   clk        - clock, all logic on rising edge
//   reset      - asynchronous, active-low reset
//   req_valid  - rule update request
//   req_ready  - block can accept a request (high only when idle)
//   rule_key   - rule value bits
//   rule_mask  - 1 = don't-care bit
//   rule_en    - 1 = program rule, 0 = invalidate slot (all-zero writes)
//   sel        - target slot
//   lut_we     - write strobe to the LUTRAM array
//   lut_addr   - LUTRAM address being written
//   lut_sel    - slot being written
//   lut_wdata  - one match bit per sub-field
//   busy       - update in progress, search must be stalled
//   done       - one-cycle pulse when an update completes
// ---------------------------------------------------------------------------
module fractcam_rule_writer #(
    parameter int key_size = 40,
    parameter int SN       = 4,
    parameter int SUB_W    = 6,
    parameter int NSUB     = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [key_size-1:0] rule_key,
    input  logic [key_size-1:0] rule_mask,
    input  logic                rule_en,
    input  logic [SN-1:0]       sel,
    output logic                lut_we,
    output logic [SUB_W-1:0]    lut_addr,
    output logic [SN-1:0]       lut_sel,
    output logic [NSUB-1:0]     lut_wdata,
    output logic                busy,
    output logic                done
);

    // Key/mask are zero-extended to a whole number of sub-fields. The
    // padded key bits are 0 and not masked, so an address with a padded
    // bit set to 1 can never match (the search side drives zeros there).
    localparam int PAD_W = NSUB * SUB_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t              state, state_nx;
    logic [SUB_W-1:0]    cnt, cnt_nx;
    logic [key_size-1:0] key_q, mask_q;
    logic                en_q;
    logic [SN-1:0]       sel_q;

    logic                accept;
    logic [key_size-1:0] key_src, mask_src;
    logic                en_src;
    logic [SN-1:0]       sel_src;
    logic [PAD_W-1:0]    key_ext, mask_ext;
    logic [NSUB-1:0]     wdata_nx;

    assign accept = req_valid & req_ready;

    // The first write happens in the cycle right after accept. Its data must
    // therefore come from the live request inputs. Later writes use the
    // captured copy.
    assign key_src  = accept ? rule_key  : key_q;
    assign mask_src = accept ? rule_mask : mask_q;
    assign en_src   = accept ? rule_en   : en_q;
    assign sel_src  = accept ? sel       : sel_q;
    assign key_ext  = PAD_W'(key_src);
    assign mask_ext = PAD_W'(mask_src);

    // Next-state and next-address logic. The counter holds the address
    // being presented. It clears when the terminal (all-ones) address is
    // written, so it never wraps inside a sweep.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (accept) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (cnt == '1) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + SUB_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Match bit per sub-field for the address about to be presented. A
    // sub-field matches when every unmasked key bit equals the address bit.
    always_comb begin
        wdata_nx = '0;
        for (int i = 0; i < NSUB; i++) begin
            wdata_nx[i] = en_src &
                (((cnt_nx ^ key_ext[i*SUB_W +: SUB_W]) &
                  ~mask_ext[i*SUB_W +: SUB_W]) == '0);
        end
    end

    // State, capture registers and registered outputs. Every output is
    // decoded from the next state, so it lines up with the state it
    // describes without any combinational path to the ports.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            key_q     <= '0;
            mask_q    <= '0;
            en_q      <= 1'b0;
            sel_q     <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            lut_we    <= 1'b0;
            lut_addr  <= '0;
            lut_sel   <= '0;
            lut_wdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                key_q  <= rule_key;
                mask_q <= rule_mask;
                en_q   <= rule_en;
                sel_q  <= sel;
            end
            req_ready <= (state_nx == IDLE);
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
            lut_we    <= (state_nx == WRITE);
            lut_addr  <= (state_nx == WRITE) ? cnt_nx   : '0;
            lut_sel   <= (state_nx == WRITE) ? sel_src  : '0;
            lut_wdata <= (state_nx == WRITE) ? wdata_nx : '0;
        end
    end

endmodule

// File: tb/tb_fractcam_rule_writer.sv
// ---------------------------------------------------------------------------
// tb_fractcam_rule_writer
//
// Scoreboard bench for fractcam_rule_writer. Each accepted request pushes its
// 64 expected array writes and its expected done cycle into queues. A monitor
// runs on the falling clock edge, pops those entries and compares them as the
// DUT presents them. The reference model derives each match bit bit-by-bit
// from the ternary rule definition.
// ---------------------------------------------------------------------------
module tb_fractcam_rule_writer;

    localparam int KEY   = 40;
    localparam int SN    = 4;
    localparam int SUB_W = 6;
    localparam int NSUB  = 7;
    localparam int NADDR = 1 << SUB_W;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [KEY-1:0]  rule_key = '0;
    logic [KEY-1:0]  rule_mask = '0;
    logic            rule_en = 1'b0;
    logic [SN-1:0]   sel = '0;
    logic            lut_we;
    logic [SUB_W-1:0] lut_addr;
    logic [SN-1:0]   lut_sel;
    logic [NSUB-1:0] lut_wdata;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [SUB_W-1:0] addr;
        logic [SN-1:0]    sel;
        logic [NSUB-1:0]  wdata;
    } exp_t;

    exp_t expQ[$];
    int   doneQ[$];
    exp_t monE;

    fractcam_rule_writer #(
        .key_size(KEY), .SN(SN), .SUB_W(SUB_W), .NSUB(NSUB)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .rule_key(rule_key), .rule_mask(rule_mask), .rule_en(rule_en), .sel(sel),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_sel(lut_sel),
        .lut_wdata(lut_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a sub-field matches address k when, for every key bit
    // position in it, either the bit is a don't-care or it equals the
    // address bit. Positions past the key width behave as key=0, unmasked.
    function automatic logic [NSUB-1:0] refMatch(input logic [KEY-1:0] key,
                                                 input logic [KEY-1:0] mask,
                                                 input logic en, input int k);
        logic [NSUB-1:0] res;
        res = '0;
        for (int i = 0; i < NSUB; i++) begin
            bit ok;
            ok = 1'b1;
            for (int b = 0; b < SUB_W; b++) begin
                int  j;
                bit  kb;
                j  = i * SUB_W + b;
                kb = ((k >> b) & 1) != 0;
                if (j < KEY) begin
                    if (!mask[j] && (key[j] != kb)) ok = 1'b0;
                end else if (kb) begin
                    ok = 1'b0;
                end
            end
            res[i] = en && ok;
        end
        return res;
    endfunction

    // Monitor: classify each cycle by what the DUT presents and compare
    // it against the scoreboard or the idle/reset expectations.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("reset_ready", req_ready, 1);
            checkOutput("reset_outs", {lut_we, busy, done, lut_addr, lut_sel, lut_wdata}, 0);
        end else if (lut_we) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("wr_addr", lut_addr, monE.addr);
                checkOutput("wr_sel", lut_sel, monE.sel);
                checkOutput("wr_data", lut_wdata, monE.wdata);
                checkOutput("wr_flags", {busy, req_ready, done}, 3'b100);
            end
        end else if (done) begin
            if (doneQ.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                checkOutput("done_cycle", cyc, doneQ.pop_front());
            end
            checkOutput("done_flags", {busy, req_ready}, 2'b10);
            checkOutput("done_after_writes", expQ.size(), 0);
        end else begin
            checkOutput("idle_flags", {busy, req_ready}, 2'b01);
            checkOutput("idle_outs", {lut_addr, lut_sel, lut_wdata}, 0);
        end
    end

    // Present one request and hold it until accepted; push expectations
    // for the edge that will accept it. Returns that edge's cycle number.
    task automatic applyStimulus(input logic [KEY-1:0] key, input logic [KEY-1:0] mask,
                                 input logic en, input logic [SN-1:0] s, output int accCyc);
        int   waitCnt;
        exp_t e;
        waitCnt = 0;
        @(negedge clk);
        rule_key  = key;
        rule_mask = mask;
        rule_en   = en;
        sel       = s;
        req_valid = 1'b1;
        while (!req_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 0, 1);
            req_valid = 1'b0;
            accCyc = -1;
            return;
        end
        accCyc = cyc + 1;
        for (int k = 0; k < NADDR; k++) begin
            e.addr  = SUB_W'(k);
            e.sel   = s;
            e.wdata = refMatch(key, mask, en, k);
            expQ.push_back(e);
        end
        doneQ.push_back(accCyc + NADDR);
        @(posedge clk);
    endtask

    task automatic releaseReq();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((expQ.size() != 0 || doneQ.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain_in_time", (n < 300), 1);
    endtask

    function automatic logic [KEY-1:0] randKey();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[KEY-1:0];
    endfunction

    // Directed scenarios first, then random rules.
    initial begin
        int a1, a2;
        logic [KEY-1:0] k, m;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_reset", {req_ready, busy, lut_we, done}, 4'b1000);

        $display("[TB] exact rule");
        applyStimulus(40'h00_0000_0003, '0, 1'b1, 4'h5, a1);
        releaseReq();
        waitIdle();

        $display("[TB] full wildcard");
        applyStimulus(randKey(), 40'hFF_FFFF_FFFF, 1'b1, 4'h7, a1);
        releaseReq();
        waitIdle();

        $display("[TB] invalidate");
        applyStimulus(randKey(), randKey(), 1'b0, 4'hA, a1);
        releaseReq();
        waitIdle();

        $display("[TB] back-to-back");
        applyStimulus(randKey(), randKey() & randKey(), 1'b1, 4'h1, a1);
        applyStimulus(randKey(), randKey() & randKey(), 1'b1, 4'h2, a2);
        releaseReq();
        checkOutput("b2b_gap", a2 - a1, 66);
        waitIdle();

        $display("[TB] reset mid-sweep");
        applyStimulus(randKey(), randKey(), 1'b1, 4'h3, a1);
        releaseReq();
        repeat (29) @(posedge clk);
        #2;
        reset = 1'b0;
        expQ.delete();
        doneQ.delete();
        #1;
        checkOutput("async_reset", {lut_we, busy, done, req_ready}, 4'b0001);
        checkOutput("async_reset_data", {lut_addr, lut_sel, lut_wdata}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        applyStimulus(40'h12_3456_789A, 40'h00_0F00_00F0, 1'b1, 4'h3, a1);
        releaseReq();
        waitIdle();

        $display("[TB] random rules");
        for (int t = 0; t < 8; t++) begin
            k = randKey();
            m = randKey() & randKey() & randKey();
            applyStimulus(k, m, ($urandom_range(0, 3) != 0), SN'($urandom_range(0, 15)), a1);
            releaseReq();
            waitIdle();
        end

        checkOutput("queues_empty", expQ.size() + doneQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
